// File: rtl/mont_pkg.sv
// Shared constants for the Montgomery multiplier and the command wrapper
// that feeds it.
//   - FSM state encodings (2-bit, legacy-compatible localparams)
//   - DEFAULT_N_BITS: operand width, also the wrapper's TX_SIZE
package mont_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOOP = 2'd1;
    localparam logic [1:0] SUB  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int DEFAULT_N_BITS = 1024;
    localparam int TX_SIZE        = DEFAULT_N_BITS;

endpackage

// File: rtl/mont_iter_step.sv
// One radix-2 Montgomery iteration, purely combinational.
//   c_i     : running accumulator C (N_BITS+2 bits, C < 2M)
//   b_i     : multiplicand B
//   m_i     : odd modulus M
//   a_bit_i : current bit of multiplier A
//   c_o     : (C + a*B + q*M) / 2, where q makes the sum even
// Kept separate so the wide adders can later be pipelined or retimed.
module mont_iter_step #(
    parameter int N_BITS = 1024
) (
    input  logic [N_BITS+1:0] c_i,
    input  logic [N_BITS-1:0] b_i,
    input  logic [N_BITS-1:0] m_i,
    input  logic              a_bit_i,
    output logic [N_BITS+1:0] c_o
);

    logic [N_BITS+1:0] t_add_b;
    logic [N_BITS+1:0] t_add_m;

    // With C < 2M and B < M, both partial sums stay below 4M, which
    // fits in N_BITS+2 bits, so no carry is lost.
    always_comb begin
        t_add_b = c_i + (a_bit_i ? {2'b00, b_i} : '0);
        t_add_m = t_add_b + (t_add_b[0] ? {2'b00, m_i} : '0);
        c_o     = t_add_m >> 1;
    end

endmodule

// File: rtl/mont_mult_core.sv
// Radix-2 bit-serial Montgomery multiplier: result = A*B*2^-N_BITS mod M.
// Ports:
//   clk, reset       : rising-edge clock, async active-high reset
//   start            : request, accepted only while idle
//   a_in, b_in, m_in : operands, captured on the accepting edge
//   busy             : high from the accepting edge until back in IDLE
//   done             : one-cycle pulse, result valid
//   result           : registered product, held until next accept/reset
//   dbg_state        : current FSM state (IDLE/LOOP/SUB/DONE)
// Handshake: start is a level sampled on every rising edge; it is only
// honoured when busy is low and is otherwise dropped, never queued.
// Latency: accept at edge 0, N_BITS loop edges, SUB at edge N_BITS+1,
// busy falls at edge N_BITS+2.
module mont_mult_core
    import mont_pkg::*;
#(
    parameter int N_BITS   = DEFAULT_N_BITS, // >= 4
    parameter int CNT_BITS = 10              // 2**CNT_BITS >= N_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_BITS-1:0] a_in,
    input  logic [N_BITS-1:0] b_in,
    input  logic [N_BITS-1:0] m_in,
    output logic              busy,
    output logic              done,
    output logic [N_BITS-1:0] result,
    output logic [1:0]        dbg_state
);

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(N_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    logic [1:0]          state_q,  state_d;
    logic [N_BITS-1:0]   a_q,      a_d;
    logic [N_BITS-1:0]   b_q,      b_d;
    logic [N_BITS-1:0]   m_q,      m_d;
    logic [N_BITS+1:0]   c_q,      c_d;
    logic [CNT_BITS-1:0] cnt_q,    cnt_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic [N_BITS-1:0]   result_q, result_d;

    logic [N_BITS+1:0]   c_next;
    logic                c_ge_m;

    // A is shifted right each iteration, so bit 0 is always A[i].
    mont_iter_step #(
        .N_BITS (N_BITS)
    ) u_step (
        .c_i     (c_q),
        .b_i     (b_q),
        .m_i     (m_q),
        .a_bit_i (a_q[0]),
        .c_o     (c_next)
    );

    assign c_ge_m = (c_q >= {2'b00, m_q});

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    m_d     = m_in;
                    c_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = LOOP;
                end
            end
            LOOP: begin
                c_d   = c_next;
                a_d   = a_q >> 1;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = SUB;
                end
            end
            SUB: begin
                // C < 2M, so one conditional subtraction suffices; the
                // low N_BITS of C-M are exact because the result is < M.
                result_d = c_ge_m ? (c_q[N_BITS-1:0] - m_q) : c_q[N_BITS-1:0];
                done_d   = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            c_q      <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mont_mult_core.sv
// Bench for mont_mult_core: an 8-bit instance checked every cycle against
// a transaction-level model, plus a 1024-bit instance for the wide case.
module tb_mont_mult_core;

    localparam int N8 = 8;
    localparam int NB = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic          rst8 = 1'b1;
    logic          start8 = 1'b0;
    logic [N8-1:0] a8 = '0, b8 = '0, m8 = '0;
    logic          busy8, done8;
    logic [N8-1:0] res8;
    logic [1:0]    st8;

    // 1024-bit instance
    logic          rst_big = 1'b1;
    logic          start_big = 1'b0;
    logic [NB-1:0] a_big = '0, b_big = '0, m_big = '0;
    logic          busy_big, done_big;
    logic [NB-1:0] res_big;
    logic [1:0]    st_big;

    mont_mult_core #(.N_BITS(N8), .CNT_BITS(4)) dut8 (
        .clk(clk), .reset(rst8), .start(start8),
        .a_in(a8), .b_in(b8), .m_in(m8),
        .busy(busy8), .done(done8), .result(res8), .dbg_state(st8)
    );

    mont_mult_core #(.N_BITS(NB), .CNT_BITS(10)) dut_big (
        .clk(clk), .reset(rst_big), .start(start_big),
        .a_in(a_big), .b_in(b_big), .m_in(m_big),
        .busy(busy_big), .done(done_big), .result(res_big), .dbg_state(st_big)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A*B*256^-1 mod M by plain arithmetic (M odd, >= 3).
    function automatic int golden(input int a, input int b, input int m);
        int rinv;
        rinv = 0;
        for (int r = 1; r < m; r++) begin
            if (((256 * r) % m) == 1) rinv = r;
        end
        return (((a * b) % m) * rinv) % m;
    endfunction

    // Transaction-level model: cycles elapsed since the accepting edge.
    int          m_cnt = -1;  // -1 = idle
    int          m_pend = 0;
    logic [7:0]  m_res = '0;
    int          accepts = 0;

    always @(posedge clk or posedge rst8) begin
        if (rst8) begin
            m_cnt = -1;
            m_res = '0;
        end else if (m_cnt < 0) begin
            if (start8) begin
                m_cnt  = 0;
                m_pend = golden(int'(a8), int'(b8), int'(m8));
                accepts++;
            end
        end else begin
            m_cnt++;
            if (m_cnt == N8 + 1) m_res = 8'(m_pend);
            if (m_cnt == N8 + 2) m_cnt = -1;
        end
    end

    logic cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 64'(busy8), 64'(m_cnt >= 0));
            chk("done", 64'(done8), 64'(m_cnt == N8 + 1));
            chk("result", 64'(res8), 64'(m_res));
        end
    end

    // Launch a transaction on the 8-bit instance, wait for done.
    // lat = negedges after the accept edge before done is seen;
    // bcyc = number of sampled cycles with busy high.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                        input bit hold, output int lat, output int bcyc);
        @(negedge clk);
        a8 = a; b8 = b; m8 = m; start8 = 1'b1;
        @(posedge clk);
        lat = -1;
        bcyc = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!hold) start8 = 1'b0;
            if (busy8) bcyc++;
            if (done8 && lat < 0) lat = n;
            if (!busy8) break;
        end
        if (lat < 0) chk("run8_timeout", 64'(0), 64'(1));
    endtask

    int lat, bcyc, dones;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy8), 64'(0));
        chk("rst_done", 64'(done8), 64'(0));
        chk("rst_result", 64'(res8), 64'(0));
        chk("rst_state", 64'(st8), 64'(0));
        rst8 = 1'b0;
        rst_big = 1'b0;
        cmp_en = 1'b1;

        // 1: basic product
        run8(8'd5, 8'd7, 8'd13, 1'b0, lat, bcyc);
        chk("t1_latency", 64'(lat), 64'(9));
        chk("t1_busy_cycles", 64'(bcyc), 64'(10));
        chk("t1_result", 64'(res8), 64'(1));

        // 2: product then start held high for back-to-back
        run8(8'd12, 8'd12, 8'd13, 1'b0, lat, bcyc);
        chk("t2_result", 64'(res8), 64'(3));
        run8(8'd12, 8'd12, 8'd13, 1'b1, lat, bcyc);
        chk("t2a_latency", 64'(lat), 64'(9));
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done8) begin lat = n; break; end
        end
        start8 = 1'b0;
        chk("t2b_second_done_seen", 64'(lat >= 0), 64'(1));
        chk("t2b_result", 64'(res8), 64'(3));
        repeat (4) @(negedge clk);

        // 3: start re-pulsed with new operands mid-operation
        @(negedge clk);
        a8 = 8'd5; b8 = 8'd7; m8 = 8'd13; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'd99; b8 = 8'd99;
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd0; b8 = 8'd0;
        dones = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8) dones++;
        end
        chk("t3_done_count", 64'(dones), 64'(1));
        chk("t3_result", 64'(res8), 64'(1));

        // 4: async reset mid-loop
        @(negedge clk);
        a8 = 8'd5; b8 = 8'd7; m8 = 8'd13; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst8 = 1'b1;
        #1;
        chk("t4_busy_async", 64'(busy8), 64'(0));
        chk("t4_done_async", 64'(done8), 64'(0));
        chk("t4_result_async", 64'(res8), 64'(0));
        repeat (2) @(negedge clk);
        rst8 = 1'b0;
        run8(8'd12, 8'd12, 8'd13, 1'b0, lat, bcyc);
        chk("t4_result_after", 64'(res8), 64'(3));

        // 5: wide instance, A = 0
        @(negedge clk);
        a_big = '0;
        for (int i = 0; i < NB / 32; i++) b_big[i*32 +: 32] = $urandom();
        m_big = '0;
        m_big[NB-1] = 1'b1;
        m_big[0] = 1'b1;
        b_big[NB-1] = 1'b0;
        start_big = 1'b1;
        @(posedge clk);
        lat = -1;
        bcyc = 0;
        for (int n = 0; n < 1200; n++) begin
            @(negedge clk);
            start_big = 1'b0;
            if (busy_big) bcyc++;
            if (done_big && lat < 0) lat = n;
            if (!busy_big) break;
        end
        chk("t5_latency", 64'(lat), 64'(1025));
        chk("t5_busy_cycles", 64'(bcyc), 64'(1026));
        chk("t5_result_ones", 64'($countones(res_big)), 64'(0));

        // 6: random transactions with operands churning every cycle
        accepts = 0;
        for (int cyc = 0; cyc < 40000 && accepts < 1000; cyc++) begin
            @(negedge clk);
            start8 = ($urandom_range(0, 3) != 0);
            m8 = 8'($urandom_range(1, 127) * 2 + 1);
            a8 = 8'($urandom_range(0, int'(m8) - 1));
            b8 = 8'($urandom_range(0, int'(m8) - 1));
        end
        start8 = 1'b0;
        chk("t6_accepts", 64'(accepts >= 1000), 64'(1));
        repeat (15) @(negedge clk);
        chk("t6_idle", 64'(busy8), 64'(0));

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
